usr_seq: RTL and testbench

USR_SEQ -- requirements
Module: usr_seq

---
 rtl/usr_pkg.sv | 39 +++
 rtl/usr_step_cnt.sv | 31 +++
 rtl/usr_seq.sv | 106 ++++++++++
 tb/tb_usr_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal-shift-register sequencer.
//   WIDTH_DEF   default width of the driven shift register
//   op_t        command opcodes carried on cmd_op
//   smode_t     mode codes driven on S to the shift register
//   state_t     sequencer FSM states
//   mode_of()   maps an opcode to the shift-register mode it runs in
package usr_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHR  = 2'b01,
      OP_SHL  = 2'b10,
      OP_ROR  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_HOLD = 2'b00,
      S_SHR  = 2'b01,
      S_SHL  = 2'b10,
      S_LOAD = 2'b11
   } smode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Rotate right is a plain right shift whose serial input is Q[0].
   function automatic smode_t mode_of(input op_t op);
      case (op)
         OP_LOAD: return S_LOAD;
         OP_SHL:  return S_SHL;
         default: return S_SHR;
      endcase
   endfunction

endpackage

// File: rtl/usr_step_cnt.sv
// usr_step_cnt: loadable 2-bit down counter with zero flag.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (count returns to 0)
//   load      load load_val (has priority over dec)
//   load_val  remaining steps minus one
//   dec       decrement request; the count saturates at 0
//   zero      count is 0 (the current step is the final one)
module usr_step_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 2'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 2'd0)) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign zero = (cnt == 2'd0);

endmodule

// File: rtl/usr_seq.sv
// usr_seq: command sequencer for a 4-bit universal shift register.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command request; accepted when cmd_valid && cmd_ready
//   cmd_ready  high exactly while idle
//   cmd_op     LOAD / SHR / SHL / ROR
//   cmd_cnt    shift steps minus one (ignored for LOAD)
//   cmd_fill   serial fill bit for SHR / SHL
//   cmd_data   parallel word for LOAD
//   q_fb       current Q of the shift register (feeds ROR)
//   S          shift-register mode (hold / right / left / load)
//   D          parallel data to the shift register
//   SR, SL     right / left serial inputs
//   busy       high exactly while a command runs
//   done       one-cycle pulse in the first idle cycle after a command
module usr_seq
   import usr_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [1:0]       cmd_cnt,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [1:0]       S,
   output logic [WIDTH-1:0] D,
   output logic             SR,
   output logic             SL,
   output logic             busy,
   output logic             done
);

   state_t     state;
   op_t        op_q;
   op_t        cmd_op_e;
   logic       sr_q;
   logic       accept;
   logic       step_zero;
   logic [1:0] cnt_load;
   logic       unused_qhi;

   assign cmd_op_e  = op_t'(cmd_op);
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state == ST_RUN);
   assign accept    = cmd_valid && cmd_ready;
   // A LOAD is a single step regardless of cmd_cnt.
   assign cnt_load  = (cmd_op_e == OP_LOAD) ? 2'd0 : cmd_cnt;

   usr_step_cnt u_step_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (cnt_load),
      .dec      (busy),
      .zero     (step_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         op_q  <= OP_LOAD;
         S     <= S_HOLD;
         D     <= '0;
         sr_q  <= 1'b0;
         SL    <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state <= ST_RUN;
                  op_q  <= cmd_op_e;
                  S     <= mode_of(cmd_op_e);
                  D     <= cmd_data;
                  sr_q  <= (cmd_op_e == OP_SHR) && cmd_fill;
                  SL    <= (cmd_op_e == OP_SHL) && cmd_fill;
               end
            end
            ST_RUN: begin
               // The edge that ends the final step returns S to hold, so the
               // register performs exactly cnt+1 (or 1 for LOAD) operations.
               if (step_zero) begin
                  state <= ST_IDLE;
                  S     <= S_HOLD;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Rotate feeds the bit about to fall off Q[0] straight back into Q[3];
   // it must track Q every step, so this path is combinational.
   assign SR = (busy && (op_q == OP_ROR)) ? q_fb[0] : sr_q;

   // Only Q[0] is needed; the upper feedback bits are intentionally unused.
   assign unused_qhi = ^q_fb[WIDTH-1:1];

endmodule

// File: tb/tb_usr_seq.sv
`timescale 1ns/1ps
module tb_usr_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [1:0] cmd_cnt = 2'd0;
   logic       cmd_fill = 1'b0;
   logic [3:0] cmd_data = 4'd0;
   logic [3:0] q = 4'd0;
   logic       cmd_ready;
   logic [1:0] S;
   logic [3:0] D;
   logic       SR, SL, busy, done;

   int nchecks = 0;
   int nerrors = 0;
   int exp_q = 0;

   always #5 clk = ~clk;

   usr_seq #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_fill  (cmd_fill),
      .cmd_data  (cmd_data),
      .q_fb      (q),
      .S         (S),
      .D         (D),
      .SR        (SR),
      .SL        (SL),
      .busy      (busy),
      .done      (done)
   );

   // Downstream 4-bit universal shift register (holds its word through reset).
   always @(posedge clk) begin
      case (S)
         2'b01:   q <= {SR, q[3:1]};
         2'b10:   q <= {q[2:0], SL};
         2'b11:   q <= D;
         default: q <= q;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: word after one operation of the given command.
   function automatic int model_step(input int qv, input int op, input int fill, input int data);
      case (op)
         0:       return data;
         1:       return (qv >> 1) | (fill << 3);
         2:       return ((qv << 1) & 15) | fill;
         default: return (qv >> 1) | ((qv & 1) << 3);
      endcase
   endfunction

   function automatic int exp_mode(input int op);
      if (op == 0) return 3;
      if (op == 2) return 2;
      return 1;
   endfunction

   task automatic scramble(input bit with_valid);
      cmd_valid = with_valid ? 1'($urandom) : 1'b0;
      cmd_op    = 2'($urandom);
      cmd_cnt   = 2'($urandom);
      cmd_fill  = 1'($urandom);
      cmd_data  = 4'($urandom);
   endtask

   // Called at a negedge with the sequencer idle; returns at the negedge of
   // the done cycle, so two consecutive calls run back-to-back.
   task automatic do_cmd(input int op, input int cnt, input int fill, input int data);
      int steps;
      int sr_exp;
      int sl_exp;
      steps  = (op == 0) ? 1 : cnt + 1;
      sr_exp = (op == 1) ? fill : 0;
      sl_exp = (op == 2) ? fill : 0;
      chk("ready_before", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op[1:0];
      cmd_cnt   = cnt[1:0];
      cmd_fill  = fill[0];
      cmd_data  = data[3:0];
      @(posedge clk);
      #1;
      for (int i = 0; i < steps; i++) begin
         scramble(1'b1);
         @(negedge clk);
         chk("S_run", S, exp_mode(op));
         chk("busy_run", busy, 1);
         chk("ready_run", cmd_ready, 0);
         chk("done_run", done, 0);
         chk("D_run", D, data);
         chk("SR_run", SR, (op == 3) ? (exp_q & 1) : sr_exp);
         chk("SL_run", SL, sl_exp);
         chk("Q_step", q, exp_q);
         exp_q = model_step(exp_q, op, fill, data);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("S_done", S, 0);
      chk("ready_done", cmd_ready, 1);
      chk("busy_done", busy, 0);
      chk("Q_final", q, exp_q);
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         scramble(1'b0);
         @(negedge clk);
         chk("S_idle", S, 0);
         chk("done_idle", done, 0);
         chk("busy_idle", busy, 0);
         chk("Q_hold", q, exp_q);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_S", S, 0);
      chk("rst_D", D, 0);
      chk("rst_SR", SR, 0);
      chk("rst_SL", SL, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_ready, 1);

      // Release and present a command together: accepted on the first edge.
      reset = 1'b1;
      do_cmd(0, 0, 0, 4'b1010);
      chk("load_1010", q, 4'b1010);
      idle(1);
      do_cmd(1, 1, 1, 0);
      chk("shr_1110", q, 4'b1110);
      idle(2);
      do_cmd(0, 0, 0, 4'b1010);
      do_cmd(2, 0, 0, 0);
      chk("shl_0100", q, 4'b0100);
      idle(1);
      do_cmd(0, 0, 0, 4'b1001);
      do_cmd(3, 3, 0, 0);
      chk("ror_restore", q, 4'b1001);
      idle(1);
      do_cmd(0, 0, 0, 4'b0101);
      chk("b2b_load", q, 4'b0101);
      do_cmd(1, 0, 0, 0);
      chk("b2b_shr", q, 4'b0010);
      idle(1);

      for (int n = 0; n < 40; n++) begin
         do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         idle(int'($urandom_range(0, 2)));
      end

      // Reset during the second step of a four-step shift.
      idle(1);
      do_cmd(0, 0, 0, 4'b1011);
      idle(1);
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_cnt   = 2'd3;
      cmd_fill  = 1'b1;
      cmd_data  = 4'd0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      exp_q = model_step(exp_q, 1, 1, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_S", S, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_SR", SR, 0);
      chk("abort_D", D, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_Q_frozen", q, exp_q);
         chk("abort_no_done", done, 0);
         chk("abort_S_hold", S, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_Q", q, exp_q);
      do_cmd(2, 2, 1, 0);
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
